// File: rtl/queue_rr_sched.sv
// queue_rr_sched: NQ logical FIFOs in one shared 1R1W RAM, RR pop to one port.
// Define QUEUE_RR_SCHED_STRICT_PRIO_EN for lowest-index-first priority grant.
module queue_rr_sched #(
  parameter  int NQ     = 4,
  parameter  int N      = 8,
  parameter  int W      = 32,
  localparam int QID_W  = $clog2(NQ),
  localparam int ADDR_W = $clog2(N),
  localparam int AW     = QID_W + ADDR_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_push_vld,
  input  logic [QID_W-1:0]  i_push_qid,
  input  logic [W-1:0]      i_push_data,
  output logic              o_push_rdy,
  output logic [NQ-1:0]     o_full,
  output logic [NQ-1:0]     o_empty,
  output logic              o_pop_vld,
  output logic [QID_W-1:0]  o_pop_qid,
  output logic [W-1:0]      o_pop_data,
  input  logic              i_pop_rdy,
  output logic              o_ram_wr_en,
  output logic [AW-1:0]     o_ram_wr_addr,
  output logic [W-1:0]      o_ram_wr_data,
  output logic              o_ram_rd_en,
  output logic [AW-1:0]     o_ram_rd_addr,
  input  logic [W-1:0]      i_ram_rd_data
);

  logic [ADDR_W:0]      wr_ptr [NQ];
  logic [ADDR_W:0]      rd_ptr [NQ];
  logic                 push_fire;
  logic                 pop_fire;
  logic                 any_elig;
  logic [QID_W-1:0]     grant;
  logic                 issue;
  logic                 inflight;
  logic [QID_W-1:0]     inflight_qid;
  logic [QID_W+W-1:0]   buf_mem [2];
  logic                 buf_wr_idx;
  logic                 buf_rd_idx;
  logic [1:0]           buf_cnt;
  logic [1:0]           occ;
  logic [1:0]           occ_after_pop;

  // Queue status straight from the pointer registers
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      o_empty[q] = rd_ptr[q] == wr_ptr[q];
      o_full[q]  = (rd_ptr[q][ADDR_W] != wr_ptr[q][ADDR_W]) &&
                   (rd_ptr[q][ADDR_W-1:0] == wr_ptr[q][ADDR_W-1:0]);
    end
  end

  assign o_push_rdy    = ~o_full[i_push_qid];
  assign push_fire     = i_push_vld & o_push_rdy;
  assign o_ram_wr_en   = push_fire;
  assign o_ram_wr_addr = {i_push_qid, wr_ptr[i_push_qid][ADDR_W-1:0]};
  assign o_ram_wr_data = i_push_data;

`ifdef QUEUE_RR_SCHED_STRICT_PRIO_EN
  // Fixed priority: lowest-index non-empty queue wins
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    for (int i = NQ - 1; i >= 0; i--) begin
      if (!o_empty[i]) begin
        grant    = QID_W'(i);
        any_elig = 1'b1;
      end
    end
  end
`else
  logic [QID_W-1:0] rr_ptr;
  logic [QID_W-1:0] idx;

  // Round-robin: first non-empty queue at or after rr_ptr
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      idx = rr_ptr + QID_W'(i);
      if (!o_empty[idx]) begin
        grant    = idx;
        any_elig = 1'b1;
      end
    end
  end

  // Advance the RR pointer past the queue just served
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      rr_ptr <= '0;
    else if (issue)
      rr_ptr <= grant + QID_W'(1);
  end
`endif

  // Occupancy counts buffered entries plus the read still in the RAM
  assign pop_fire      = o_pop_vld & i_pop_rdy;
  assign occ           = buf_cnt + {1'b0, inflight};
  assign occ_after_pop = occ - {1'b0, pop_fire};
  assign issue         = any_elig & (occ_after_pop < 2'd2);

  assign o_ram_rd_en   = issue;
  assign o_ram_rd_addr = {grant, rd_ptr[grant][ADDR_W-1:0]};

  // Per-queue pointers; push and issue advance independently
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (push_fire && i_push_qid == QID_W'(q))
          wr_ptr[q] <= wr_ptr[q] + 1'b1;
        if (issue && grant == QID_W'(q))
          rd_ptr[q] <= rd_ptr[q] + 1'b1;
      end
    end
  end

  // Track the one outstanding RAM read and its source queue
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inflight     <= 1'b0;
      inflight_qid <= '0;
    end else begin
      inflight <= issue;
      if (issue)
        inflight_qid <= grant;
    end
  end

  // Output buffer control; reset drops any returning read
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      buf_wr_idx <= 1'b0;
      buf_rd_idx <= 1'b0;
      buf_cnt    <= '0;
    end else begin
      if (inflight)
        buf_wr_idx <= ~buf_wr_idx;
      if (pop_fire)
        buf_rd_idx <= ~buf_rd_idx;
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop_fire};
    end
  end

  // Output buffer storage, written as RAM data returns
  always_ff @(posedge clk) begin
    if (inflight)
      buf_mem[buf_wr_idx] <= {inflight_qid, i_ram_rd_data};
  end

  assign o_pop_vld              = buf_cnt != 2'd0;
  assign {o_pop_qid, o_pop_data} = buf_mem[buf_rd_idx];

endmodule

// File: tb/tb_queue_rr_sched.sv
// tb_queue_rr_sched: random and directed stimulus, scoreboard vs queue model.
// Model tracks queue contents, scheduler order and output latency.
module tb_queue_rr_sched;

  localparam int NQ = 4;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int QW = $clog2(NQ);
  localparam int AW = QW + $clog2(N);

  logic          clk = 1'b0;
  logic          arst_n;
  logic          i_push_vld;
  logic [QW-1:0] i_push_qid;
  logic [W-1:0]  i_push_data;
  logic          o_push_rdy;
  logic [NQ-1:0] o_full;
  logic [NQ-1:0] o_empty;
  logic          o_pop_vld;
  logic [QW-1:0] o_pop_qid;
  logic [W-1:0]  o_pop_data;
  logic          i_pop_rdy;
  logic          o_ram_wr_en;
  logic [AW-1:0] o_ram_wr_addr;
  logic [W-1:0]  o_ram_wr_data;
  logic          o_ram_rd_en;
  logic [AW-1:0] o_ram_rd_addr;
  logic [W-1:0]  ram_rd_data;

  queue_rr_sched #(.NQ(NQ), .N(N), .W(W)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .i_push_vld    (i_push_vld),
    .i_push_qid    (i_push_qid),
    .i_push_data   (i_push_data),
    .o_push_rdy    (o_push_rdy),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_pop_vld     (o_pop_vld),
    .o_pop_qid     (o_pop_qid),
    .o_pop_data    (o_pop_data),
    .i_pop_rdy     (i_pop_rdy),
    .o_ram_wr_en   (o_ram_wr_en),
    .o_ram_wr_addr (o_ram_wr_addr),
    .o_ram_wr_data (o_ram_wr_data),
    .o_ram_rd_en   (o_ram_rd_en),
    .o_ram_rd_addr (o_ram_rd_addr),
    .i_ram_rd_data (ram_rd_data)
  );

  always #5 clk = ~clk;

  // External RAM: one-cycle read latency
  logic [W-1:0] ram [NQ*N];
  always @(posedge clk) begin
    if (o_ram_wr_en) ram[o_ram_wr_addr] <= o_ram_wr_data;
    if (o_ram_rd_en) ram_rd_data <= ram[o_ram_rd_addr];
  end

  typedef struct {
    int           qid;
    logic [W-1:0] data;
    int           t;
  } ent_t;

  logic [W-1:0] data_q [NQ][$];
  ent_t         out_q [$];
  ent_t         e;
  int           cnt [NQ];
  int           wcnt [NQ];
  int           rcnt [NQ];
  int           rr;
  int           cyc;
  int           vecs;
  int           errs;
  int           g, mq, pq;
  bit           any, e_rdy, e_wr, e_vld, e_pop, e_iss;
  logic [NQ-1:0] e_empty, e_full;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT to the model, then advance the model one cycle
  always @(negedge clk) begin
    if (!arst_n) begin
      for (int q = 0; q < NQ; q++) begin
        data_q[q].delete();
        cnt[q]  = 0;
        wcnt[q] = 0;
        rcnt[q] = 0;
      end
      out_q.delete();
      rr = 0;
      chk("rst_empty", o_empty, {NQ{1'b1}});
      chk("rst_full", o_full, '0);
      chk("rst_pop_vld", o_pop_vld, 0);
      chk("rst_rd_en", o_ram_rd_en, 0);
      chk("rst_wr_en", o_ram_wr_en, 0);
    end else begin
      for (int q = 0; q < NQ; q++) begin
        e_empty[q] = cnt[q] == 0;
        e_full[q]  = cnt[q] == N;
      end
      chk("empty", o_empty, e_empty);
      chk("full", o_full, e_full);
      pq    = int'(i_push_qid);
      e_rdy = cnt[pq] < N;
      chk("push_rdy", o_push_rdy, e_rdy);
      e_wr = i_push_vld && e_rdy;
      chk("wr_en", o_ram_wr_en, e_wr);
      if (e_wr) begin
        chk("wr_addr", o_ram_wr_addr, pq * N + wcnt[pq] % N);
        chk("wr_data", o_ram_wr_data, i_push_data);
      end
      e_vld = out_q.size() > 0 && out_q[0].t <= cyc;
      chk("pop_vld", o_pop_vld, e_vld);
      if (e_vld) begin
        chk("pop_qid", o_pop_qid, out_q[0].qid);
        chk("pop_data", o_pop_data, out_q[0].data);
      end
      e_pop = e_vld && i_pop_rdy;
      any = 0;
      g   = 0;
      for (int i = 0; i < NQ; i++) begin
`ifdef QUEUE_RR_SCHED_STRICT_PRIO_EN
        mq = i;
`else
        mq = (rr + i) % NQ;
`endif
        if (!any && cnt[mq] > 0) begin
          any = 1;
          g   = mq;
        end
      end
      e_iss = any && (out_q.size() - int'(e_pop)) < 2;
      chk("rd_en", o_ram_rd_en, e_iss);
      if (e_iss)
        chk("rd_addr", o_ram_rd_addr, g * N + rcnt[g] % N);
      if (e_wr) begin
        data_q[pq].push_back(i_push_data);
        cnt[pq]++;
        wcnt[pq]++;
      end
      if (e_pop)
        void'(out_q.pop_front());
      if (e_iss) begin
        e.qid  = g;
        e.data = data_q[g].pop_front();
        e.t    = cyc + 2;
        out_q.push_back(e);
        cnt[g]--;
        rcnt[g]++;
        rr = (g + 1) % NQ;
      end
      cyc++;
    end
  end

  task automatic step(bit v, int q, logic [W-1:0] d, bit r);
    i_push_vld  = v;
    i_push_qid  = QW'(q);
    i_push_data = d;
    i_pop_rdy   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    cyc  = 0;
    rr   = 0;
    i_push_vld  = 0;
    i_push_qid  = '0;
    i_push_data = '0;
    i_pop_rdy   = 0;
    arst_n = 1;
    #1 arst_n = 0;
    repeat (3) @(posedge clk);
    #1 arst_n = 1;

    step(1, 2, 32'hA5, 1);
    repeat (5) step(0, 0, 0, 1);

    for (int i = 0; i < 12; i++) step(1, 1, 32'h100 + i, 0);
    repeat (4) step(0, 0, 0, 0);
    repeat (14) step(0, 0, 0, 1);

    for (int q = 0; q < NQ; q++) begin
      step(1, q, 32'h200 + q * 2, 0);
      step(1, q, 32'h201 + q * 2, 0);
    end
    repeat (12) step(0, 0, 0, 1);

    for (int i = 0; i < 5; i++) step(1, 0, 32'h300 + i, 0);
    repeat (6) step(0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1);

    for (int i = 0; i < 16; i++) begin
      step(1, 0, 32'h400 + i, 1);
      step(0, 0, 0, 1);
    end
    repeat (4) step(0, 0, 0, 1);

    for (int i = 0; i < 6; i++) step(1, 3, 32'h500 + i, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h600 + i, 0);
    repeat (20) step(0, 0, 0, 1);

    step(1, 0, 32'h700, 1);
    step(1, 0, 32'h701, 1);
    i_push_vld = 0;
    arst_n = 0;
    repeat (3) @(posedge clk);
    #1 arst_n = 1;
    repeat (6) step(0, 0, 0, 1);

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, NQ - 1),
           $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, NQ - 1),
           $urandom, $urandom_range(0, 3) == 0);
    repeat (60) step(0, 0, 0, 1);

    #3;
    chk("drain_empty", o_empty, {NQ{1'b1}});
    chk("drain_pop_vld", o_pop_vld, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
